// File: rtl/fifo_tx_pkg.sv
// Shared sizing for the I2C transmit FIFO: default word/address widths, depth, error-flag layout.
package fifo_tx_pkg;

  localparam int unsigned FIFO_TX_DWIDTH = 32;
  localparam int unsigned FIFO_TX_AWIDTH = 5;
  localparam int unsigned FIFO_TX_DEPTH  = 1 << FIFO_TX_AWIDTH;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_tx_err_t;

  function automatic int unsigned fifo_tx_depth(input int unsigned awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/fifo_tx_if.sv
// APB-side push / I2C-side pop bundle of the transmit FIFO; master drives requests, slave is the FIFO.
// TX_LEVEL exists only when FIFO_TX_LEVEL_EN is defined.
interface fifo_tx_if
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DWIDTH = FIFO_TX_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_TX_AWIDTH
) ();

  logic              WR_ENA;
  logic [DWIDTH-1:0] WRITE_DATA_ON_TX;
  logic              RD_ENA;
  logic              CLR_ERR;
  logic [DWIDTH-1:0] DATA_OUT;
  logic              DATA_VALID;
  logic              TX_FULL;
  logic              TX_EMPTY;
  logic              ERROR;
`ifdef FIFO_TX_LEVEL_EN
  logic [AWIDTH:0]   TX_LEVEL;
`endif

  modport master (
    output WR_ENA, WRITE_DATA_ON_TX, RD_ENA, CLR_ERR,
`ifdef FIFO_TX_LEVEL_EN
    input  TX_LEVEL,
`endif
    input  DATA_OUT, DATA_VALID, TX_FULL, TX_EMPTY, ERROR
  );

  modport slave (
    input  WR_ENA, WRITE_DATA_ON_TX, RD_ENA, CLR_ERR,
`ifdef FIFO_TX_LEVEL_EN
    output TX_LEVEL,
`endif
    output DATA_OUT, DATA_VALID, TX_FULL, TX_EMPTY, ERROR
  );

endinterface

// File: rtl/fifo_tx_mem.sv
// Simple dual-port storage: synchronous write, synchronous read-before-write read register, no reset.
// Read data appears the cycle after rd_en and is held otherwise; no backpressure.
module fifo_tx_mem
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DWIDTH = FIFO_TX_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_TX_AWIDTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_dat
);

  localparam int unsigned DEPTH = fifo_tx_depth(AWIDTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_dat_q;

  // A same-address write and read on one edge returns the old word, which is
  // exactly what a simultaneous push/pop on a full FIFO needs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat_q <= mem_q[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_tx.sv
// I2C transmit FIFO (32x32 default): push accepted on the edge, popped word on DATA_OUT one cycle after RD_ENA.
// No backpressure: push-when-full and pop-when-empty are dropped and latch sticky ERROR. Optional TX_LEVEL via FIFO_TX_LEVEL_EN.
module fifo_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DWIDTH = FIFO_TX_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_TX_AWIDTH
) (
  input  logic     PCLK,
  input  logic     PRESET,
  fifo_tx_if.slave bus
);

  localparam int unsigned     DEPTH    = fifo_tx_depth(AWIDTH);
  localparam logic [AWIDTH:0] CNT_FULL = DEPTH[AWIDTH:0];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              dat_vld_q, dat_vld_d;
  logic              out_clr_q, out_clr_d;
  fifo_tx_err_t      err_q, err_d;

  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              udf_evt;
  logic [DWIDTH-1:0] rd_dat;

  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == '0);
    do_pop  = bus.RD_ENA && !empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO is still legal.
    do_push = bus.WR_ENA && (!full || do_pop);
    ovf_evt = bus.WR_ENA && full && !do_pop;
    udf_evt = bus.RD_ENA && empty;

    wr_ptr_d = do_push ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AWIDTH + 1)'(1);
      2'b01:   count_d = count_q - (AWIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    dat_vld_d = do_pop;
    out_clr_d = out_clr_q && !do_pop;

    err_d.ovf = ovf_evt || (err_q.ovf && !bus.CLR_ERR);
    err_d.udf = udf_evt || (err_q.udf && !bus.CLR_ERR);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dat_vld_q <= 1'b0;
      out_clr_q <= 1'b1;
      err_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dat_vld_q <= dat_vld_d;
      out_clr_q <= out_clr_d;
      err_q     <= err_d;
    end
  end

  fifo_tx_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (PCLK),
    .wr_en   (do_push && !PRESET),
    .wr_addr (wr_ptr_q),
    .wr_dat  (bus.WRITE_DATA_ON_TX),
    .rd_en   (do_pop && !PRESET),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_dat)
  );

  // The read register has no reset; out_clr_q masks it to zero until the first pop after reset.
  assign bus.DATA_OUT   = out_clr_q ? '0 : rd_dat;
  assign bus.DATA_VALID = dat_vld_q;
  assign bus.TX_FULL    = full;
  assign bus.TX_EMPTY   = empty;
  assign bus.ERROR      = err_q.ovf || err_q.udf;

`ifdef FIFO_TX_LEVEL_EN
  assign bus.TX_LEVEL   = count_q;
`endif

endmodule

// File: tb/tb_fifo_tx.sv
// Directed test of fifo_tx: ordering, full/overflow, empty/underflow, full push+pop, pointer wrap, reset.
module tb_fifo_tx;
  import fifo_tx_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 PCLK = ~PCLK;

  fifo_tx_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

  fifo_tx #(.DWIDTH(32), .AWIDTH(5)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESET               = 1'b1;
    bus.WR_ENA           = 1'b0;
    bus.RD_ENA           = 1'b0;
    bus.CLR_ERR          = 1'b0;
    bus.WRITE_DATA_ON_TX = '0;
    tick();
    tick();
    PRESET = 1'b0;

    chk_bit ("rst_empty", bus.TX_EMPTY, 1'b1);
    chk_bit ("rst_full", bus.TX_FULL, 1'b0);
    chk_bit ("rst_error", bus.ERROR, 1'b0);
    chk_bit ("rst_valid", bus.DATA_VALID, 1'b0);
    chk_word("rst_dout", bus.DATA_OUT, 32'h0);

    // three pushes then three pops, same order
    bus.WR_ENA = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.WRITE_DATA_ON_TX = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    bus.WR_ENA = 1'b0;
    chk_bit("push3_empty", bus.TX_EMPTY, 1'b0);
    chk_bit("push3_valid", bus.DATA_VALID, 1'b0);
    bus.RD_ENA = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_bit ("pop3_valid", bus.DATA_VALID, 1'b1);
      chk_word("pop3_dout", bus.DATA_OUT, 32'hA5A5_0000 + 32'(i));
    end
    chk_bit("pop3_empty", bus.TX_EMPTY, 1'b1);

    // pop on empty: ignored, sticky underflow
    tick();
    chk_bit ("udf_valid", bus.DATA_VALID, 1'b0);
    chk_bit ("udf_error", bus.ERROR, 1'b1);
    chk_word("udf_dout_hold", bus.DATA_OUT, 32'hA5A5_0003);
    bus.CLR_ERR = 1'b1;
    tick();
    chk_bit("clr_vs_udf_error", bus.ERROR, 1'b1);
    bus.RD_ENA = 1'b0;
    tick();
    chk_bit("clr_error", bus.ERROR, 1'b0);
    bus.CLR_ERR = 1'b0;

    // pop on empty with push: push lands, pop ignored
    bus.RD_ENA           = 1'b1;
    bus.WR_ENA           = 1'b1;
    bus.WRITE_DATA_ON_TX = 32'h0BAD_F00D;
    tick();
    chk_bit ("udfpush_valid", bus.DATA_VALID, 1'b0);
    chk_bit ("udfpush_error", bus.ERROR, 1'b1);
    chk_bit ("udfpush_empty", bus.TX_EMPTY, 1'b0);
    chk_word("udfpush_dout", bus.DATA_OUT, 32'hA5A5_0003);
    bus.WR_ENA  = 1'b0;
    bus.CLR_ERR = 1'b1;
    tick();
    chk_bit ("udfpush_pop_valid", bus.DATA_VALID, 1'b1);
    chk_word("udfpush_pop_dout", bus.DATA_OUT, 32'h0BAD_F00D);
    chk_bit ("udfpush_pop_empty", bus.TX_EMPTY, 1'b1);
    chk_bit ("udfpush_clr", bus.ERROR, 1'b0);
    bus.RD_ENA  = 1'b0;
    bus.CLR_ERR = 1'b0;

    // fill to 32, then overflow
    bus.WR_ENA = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.WRITE_DATA_ON_TX = 32'hC000_0000 + 32'(i);
      tick();
      chk_bit("fill_full", bus.TX_FULL, (i == 31) ? 1'b1 : 1'b0);
    end
    bus.WRITE_DATA_ON_TX = 32'hDEAD_BEEF;
    tick();
    chk_bit("ovf_error", bus.ERROR, 1'b1);
    chk_bit("ovf_full", bus.TX_FULL, 1'b1);
    bus.WR_ENA  = 1'b0;
    bus.CLR_ERR = 1'b1;
    tick();
    chk_bit("ovf_clr", bus.ERROR, 1'b0);
    chk_bit("ovf_clr_full", bus.TX_FULL, 1'b1);
    bus.CLR_ERR = 1'b0;

    // push+pop while full: accepted, no overflow, new word comes out 32nd
    bus.WR_ENA           = 1'b1;
    bus.RD_ENA           = 1'b1;
    bus.WRITE_DATA_ON_TX = 32'h1234_5678;
    tick();
    chk_bit ("fullpp_valid", bus.DATA_VALID, 1'b1);
    chk_word("fullpp_dout", bus.DATA_OUT, 32'hC000_0000);
    chk_bit ("fullpp_error", bus.ERROR, 1'b0);
    chk_bit ("fullpp_full", bus.TX_FULL, 1'b1);
    bus.WR_ENA = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      chk_word("drain_dout", bus.DATA_OUT, 32'hC000_0000 + 32'(i));
      chk_bit ("drain_full", bus.TX_FULL, 1'b0);
    end
    tick();
    chk_word("drain_new_word", bus.DATA_OUT, 32'h1234_5678);
    chk_bit ("drain_empty", bus.TX_EMPTY, 1'b1);
    bus.RD_ENA = 1'b0;

    // steady state at count 1 across several pointer wraps
    bus.WR_ENA           = 1'b1;
    bus.WRITE_DATA_ON_TX = 32'h5000_0000;
    tick();
    bus.RD_ENA = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      bus.WRITE_DATA_ON_TX = 32'h5000_0000 + 32'(k);
      tick();
      chk_word("wrap_dout", bus.DATA_OUT, 32'h5000_0000 + 32'(k - 1));
      chk_bit ("wrap_valid", bus.DATA_VALID, 1'b1);
    end
    bus.WR_ENA = 1'b0;
    tick();
    chk_word("wrap_last", bus.DATA_OUT, 32'h5000_0064);
    chk_bit ("wrap_empty", bus.TX_EMPTY, 1'b1);
    chk_bit ("wrap_error", bus.ERROR, 1'b0);

    // reset with 5 words stored and a pending error
    tick();
    chk_bit("pre_rst_udf", bus.ERROR, 1'b1);
    bus.RD_ENA = 1'b0;
    bus.WR_ENA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.WRITE_DATA_ON_TX = 32'h7000_0000 + 32'(i);
      tick();
    end
    chk_bit("pre_rst_empty", bus.TX_EMPTY, 1'b0);
    PRESET     = 1'b1;
    bus.RD_ENA = 1'b1;
    tick();
    chk_bit ("midrst_empty", bus.TX_EMPTY, 1'b1);
    chk_bit ("midrst_full", bus.TX_FULL, 1'b0);
    chk_bit ("midrst_error", bus.ERROR, 1'b0);
    chk_bit ("midrst_valid", bus.DATA_VALID, 1'b0);
    chk_word("midrst_dout", bus.DATA_OUT, 32'h0);
    PRESET     = 1'b0;
    bus.WR_ENA = 1'b0;
    tick();
    chk_bit ("postrst_valid", bus.DATA_VALID, 1'b0);
    chk_bit ("postrst_udf", bus.ERROR, 1'b1);
    chk_word("postrst_dout", bus.DATA_OUT, 32'h0);
    bus.RD_ENA = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
